// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for the 32-entry register file: CPU single writes vs DMA bursts.
// Optional build macro REG_WRITE_ARBITER_R0_PROTECT_EN makes register 0 read-only and adds r0_viol.
module reg_write_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int NREG      = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_base,
  input  logic [3:0]        dma_len,
  input  logic              dma_valid,
  input  logic [DATA_W-1:0] dma_data,
  output logic              dma_rdy,
  output logic              dma_done,
  output logic [NREG-1:0]   wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
`ifdef REG_WRITE_ARBITER_R0_PROTECT_EN
  ,
  output logic              r0_viol
`endif
);

  typedef enum logic [1:0] {IDLE, CPU_WR, DMA_BURST} state_t;
  typedef enum logic {GRANT_CPU, GRANT_DMA} grant_t;

  state_t              state_reg;
  grant_t              last_grant_reg;
  logic [ADDR_W-1:0]   addr_ptr_reg;
  logic [3:0]          beats_left_reg;

  logic [NREG-1:0]     cpu_onehot;
  logic [NREG-1:0]     ptr_onehot;
  logic                cpu_blocked;
  logic                ptr_blocked;
  logic [3:0]          eff_len;
  logic                grant_cpu;
  logic                grant_dma;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_decode
      assign cpu_onehot[gi] = (cpu_addr == ADDR_W'(gi));
      assign ptr_onehot[gi] = (addr_ptr_reg == ADDR_W'(gi));
    end
  endgenerate

`ifdef REG_WRITE_ARBITER_R0_PROTECT_EN
  assign cpu_blocked = (cpu_addr == '0);
  assign ptr_blocked = (addr_ptr_reg == '0);
`else
  assign cpu_blocked = 1'b0;
  assign ptr_blocked = 1'b0;
`endif

  // A zero-length request still moves one beat; long requests are cut so the CPU gets a turn.
  always_comb begin
    eff_len = dma_len;
    if (dma_len == 4'd0) begin
      eff_len = 4'd1;
    end else if (dma_len > 4'(MAX_BURST)) begin
      eff_len = 4'(MAX_BURST);
    end
  end

  // On a tie the requester that did not win last time gets the grant.
  assign grant_cpu = cpu_req && (!dma_req || last_grant_reg == GRANT_DMA);
  assign grant_dma = dma_req && (!cpu_req || last_grant_reg == GRANT_CPU);

  assign busy    = (state_reg != IDLE);
  assign dma_rdy = (state_reg == DMA_BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_DMA;
      addr_ptr_reg   <= '0;
      beats_left_reg <= '0;
      wr_en          <= '0;
      wr_addr        <= '0;
      wr_data        <= '0;
      cpu_ack        <= 1'b0;
      dma_done       <= 1'b0;
`ifdef REG_WRITE_ARBITER_R0_PROTECT_EN
      r0_viol        <= 1'b0;
`endif
    end else begin
      wr_en    <= '0;
      wr_addr  <= '0;
      cpu_ack  <= 1'b0;
      dma_done <= 1'b0;
`ifdef REG_WRITE_ARBITER_R0_PROTECT_EN
      r0_viol  <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (grant_cpu) begin
            state_reg      <= CPU_WR;
            last_grant_reg <= GRANT_CPU;
            wr_en          <= cpu_blocked ? '0 : cpu_onehot;
            wr_addr        <= cpu_addr;
            wr_data        <= cpu_data;
            cpu_ack        <= 1'b1;
`ifdef REG_WRITE_ARBITER_R0_PROTECT_EN
            r0_viol        <= cpu_blocked;
`endif
          end else if (grant_dma) begin
            state_reg      <= DMA_BURST;
            last_grant_reg <= GRANT_DMA;
            addr_ptr_reg   <= dma_base;
            beats_left_reg <= eff_len;
          end
        end
        CPU_WR: begin
          state_reg <= IDLE;
        end
        DMA_BURST: begin
          if (dma_valid) begin
            wr_en          <= ptr_blocked ? '0 : ptr_onehot;
            wr_addr        <= addr_ptr_reg;
            wr_data        <= dma_data;
            addr_ptr_reg   <= addr_ptr_reg + ADDR_W'(1);
            beats_left_reg <= beats_left_reg - 4'd1;
`ifdef REG_WRITE_ARBITER_R0_PROTECT_EN
            r0_viol        <= ptr_blocked;
`endif
            if (beats_left_reg == 4'd1) begin
              state_reg <= IDLE;
              dma_done  <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: every observed write is popped from an expectation queue.
// Build with REG_WRITE_ARBITER_R0_PROTECT_EN defined to also exercise the read-only register 0.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cpu_req = 1'b0;
  logic [4:0]  cpu_addr = '0;
  logic [31:0] cpu_data = '0;
  logic        cpu_ack;
  logic        dma_req = 1'b0;
  logic [4:0]  dma_base = '0;
  logic [3:0]  dma_len = '0;
  logic        dma_valid = 1'b0;
  logic [31:0] dma_data = '0;
  logic        dma_rdy;
  logic        dma_done;
  logic [31:0] wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
`ifdef REG_WRITE_ARBITER_R0_PROTECT_EN
  logic        r0_viol;
  localparam logic [31:0] R0_EN = 32'h0;
`else
  localparam logic [31:0] R0_EN = 32'h1;
`endif

  always #5 clk = ~clk;

  reg_write_arbiter #(.ADDR_W(5), .DATA_W(32), .NREG(32), .MAX_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_base(dma_base), .dma_len(dma_len), .dma_valid(dma_valid),
    .dma_data(dma_data), .dma_rdy(dma_rdy), .dma_done(dma_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
`ifdef REG_WRITE_ARBITER_R0_PROTECT_EN
    , .r0_viol(r0_viol)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ack;
    logic        done;
    logic        viol;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic mon_ev;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_en;
  } cpu_vec_t;
  cpu_vec_t cpu_vecs[4];

  typedef struct {
    logic [4:0] base;
    logic [3:0] len;
    int         exp_beats;
  } dma_vec_t;
  dma_vec_t dma_vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] en_for(input logic [4:0] a);
`ifdef REG_WRITE_ARBITER_R0_PROTECT_EN
    if (a == 5'd0) return 32'h0;
`endif
    return 32'h1 << a;
  endfunction

  function automatic logic viol_for(input logic [4:0] a);
`ifdef REG_WRITE_ARBITER_R0_PROTECT_EN
    return (a == 5'd0);
`else
    return (a != a);
`endif
  endfunction

  task automatic push_write(input logic [31:0] en, input logic [4:0] a, input logic [31:0] d,
                            input logic ack, input logic done);
    exp_t e;
    e.en = en; e.addr = a; e.data = d; e.ack = ack; e.done = done; e.viol = viol_for(a);
    sb.push_back(e);
  endtask

  task automatic push_dma(input logic [4:0] base, input int n, input logic [31:0] seed);
    for (int i = 0; i < n; i++) begin
      logic [4:0] a;
      a = base + 5'(i);
      push_write(en_for(a), a, seed + 32'(i), 1'b0, (i == n - 1));
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_ev = (wr_en != 32'h0) || cpu_ack || dma_done;
`ifdef REG_WRITE_ARBITER_R0_PROTECT_EN
      mon_ev = mon_ev || r0_viol;
`endif
      if (mon_ev) begin
        $display("write: en=%08h addr=%0d data=%08h ack=%0b done=%0b", wr_en, wr_addr, wr_data, cpu_ack, dma_done);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got en=%08h addr=%0d data=%08h, required no write", wr_en, wr_addr, wr_data);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_wr_en", wr_en, mon_e.en);
          chk("sb_wr_addr", wr_addr, mon_e.addr);
          chk("sb_wr_data", wr_data, mon_e.data);
          chk("sb_cpu_ack", cpu_ack, mon_e.ack);
          chk("sb_dma_done", dma_done, mon_e.done);
`ifdef REG_WRITE_ARBITER_R0_PROTECT_EN
          chk("sb_r0_viol", r0_viol, mon_e.viol);
`endif
        end
      end else begin
        chk("idle_wr_addr", wr_addr, 5'd0);
      end
    end
  end

  task automatic do_reset();
    chk("sb_drained", sb.size(), 0);
    @(negedge clk);
    rst_n = 1'b0;
    cpu_req = 1'b0; dma_req = 1'b0; dma_valid = 1'b0;
    #1;
    chk("rst_wr_en", wr_en, 32'h0);
    chk("rst_wr_addr", wr_addr, 5'd0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_cpu_ack", cpu_ack, 1'b0);
    chk("rst_dma_done", dma_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dma_rdy", dma_rdy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cpu_run(input logic [4:0] a, input logic [31:0] d);
    int cnt;
    cnt = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = a; cpu_data = d;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!cpu_ack && cnt < 100);
    if (!cpu_ack) begin
      n_checks++;
      n_fail++;
      $display("FAIL cpu_ack_timeout: got no ack after %0d cycles, required an ack", cnt);
    end
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  // Drives beats for as long as the DUT keeps dma_rdy high; returns the number of beats accepted.
  task automatic dma_run(input logic [4:0] base, input logic [3:0] len, input logic [31:0] seed,
                         input int gap_after, input int gap_cycles, output int accepted);
    int  cnt;
    int  gap;
    bit  started;
    accepted = 0; cnt = 0; gap = 0; started = 0;
    @(negedge clk);
    dma_req = 1'b1; dma_base = base; dma_len = len; dma_valid = 1'b0;
    while (cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (dma_rdy) begin
        started = 1;
        dma_req = 1'b0;
        if (accepted == gap_after && gap < gap_cycles) begin
          dma_valid = 1'b0;
          gap++;
        end else begin
          dma_valid = 1'b1;
          dma_data  = seed + 32'(accepted);
          accepted++;
        end
      end else if (started) begin
        break;
      end else begin
        dma_valid = 1'b0;
      end
    end
    dma_valid = 1'b0;
    dma_req   = 1'b0;
    if (cnt >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL dma_timeout: got started=%0d accepted=%0d, required burst to finish", started, accepted);
    end
  endtask

  initial begin
    int acc;
    logic [31:0] t2_en[4];

    cpu_vecs[0] = '{addr: 5'd3,  data: 32'h0000_1111, exp_en: 32'h0000_0008};
    cpu_vecs[1] = '{addr: 5'd0,  data: 32'hA5A5_0000, exp_en: R0_EN};
    cpu_vecs[2] = '{addr: 5'd31, data: 32'hFFFF_0001, exp_en: 32'h8000_0000};
    cpu_vecs[3] = '{addr: 5'd17, data: 32'h1234_5678, exp_en: 32'h0002_0000};

    dma_vecs[0] = '{base: 5'd3,  len: 4'd0,  exp_beats: 1};
    dma_vecs[1] = '{base: 5'd10, len: 4'd12, exp_beats: 8};
    dma_vecs[2] = '{base: 5'd25, len: 4'd8,  exp_beats: 8};
    dma_vecs[3] = '{base: 5'd7,  len: 4'd1,  exp_beats: 1};
    dma_vecs[4] = '{base: 5'd28, len: 4'd15, exp_beats: 8};

    do_reset();

    // Single CPU write latency.
    push_write(32'h0000_0020, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 5'd5; cpu_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    chk("t1_wr_en", wr_en, 32'h0000_0020);
    chk("t1_ack", cpu_ack, 1'b1);
    chk("t1_busy", busy, 1'b1);
    @(negedge clk);
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    chk("t1_ack_low", cpu_ack, 1'b0);
    chk("t1_wr_en_low", wr_en, 32'h0);
    chk("t1_busy_low", busy, 1'b0);

    // Tie right after reset: CPU first, then the waiting DMA.
    do_reset();
    push_write(32'h0000_0200, 5'd9, 32'hC0DE_0001, 1'b1, 1'b0);
    push_dma(5'd8, 2, 32'h0000_0100);
    fork
      cpu_run(5'd9, 32'hC0DE_0001);
      dma_run(5'd8, 4'd2, 32'h0000_0100, 0, 0, acc);
    join
    chk("r1_dma_beats", acc, 2);

    for (int i = 0; i < 4; i++) begin
      push_write(cpu_vecs[i].exp_en, cpu_vecs[i].addr, cpu_vecs[i].data, 1'b1, 1'b0);
      cpu_run(cpu_vecs[i].addr, cpu_vecs[i].data);
    end

    // Tie after a CPU grant: DMA wins.
    push_dma(5'd12, 3, 32'h0000_0200);
    push_write(32'h0000_0040, 5'd6, 32'hC0DE_0002, 1'b1, 1'b0);
    fork
      cpu_run(5'd6, 32'hC0DE_0002);
      dma_run(5'd12, 4'd3, 32'h0000_0200, 0, 0, acc);
    join
    chk("r2_dma_beats", acc, 3);

    // Burst wrapping 31 -> 0.
    t2_en[0] = 32'h4000_0000; t2_en[1] = 32'h8000_0000; t2_en[2] = R0_EN; t2_en[3] = 32'h0000_0002;
    push_write(t2_en[0], 5'd30, 32'd1, 1'b0, 1'b0);
    push_write(t2_en[1], 5'd31, 32'd2, 1'b0, 1'b0);
    push_write(t2_en[2], 5'd0,  32'd3, 1'b0, 1'b0);
    push_write(t2_en[3], 5'd1,  32'd4, 1'b0, 1'b1);
    dma_run(5'd30, 4'd4, 32'd1, 0, 0, acc);
    chk("t2_dma_beats", acc, 4);

    // Tie after a DMA grant: CPU wins.
    push_write(32'h0000_0800, 5'd11, 32'hC0DE_0003, 1'b1, 1'b0);
    push_dma(5'd20, 2, 32'h0000_0300);
    fork
      cpu_run(5'd11, 32'hC0DE_0003);
      dma_run(5'd20, 4'd2, 32'h0000_0300, 0, 0, acc);
    join
    chk("r3_dma_beats", acc, 2);

    for (int i = 0; i < 5; i++) begin
      push_dma(dma_vecs[i].base, dma_vecs[i].exp_beats, 32'h0001_0000 * 32'(i + 1));
      dma_run(dma_vecs[i].base, dma_vecs[i].len, 32'h0001_0000 * 32'(i + 1), 0, 0, acc);
      chk("len_dma_beats", acc, dma_vecs[i].exp_beats);
    end

    // Two idle cycles after the second beat.
    push_dma(5'd4, 4, 32'h0000_0400);
    dma_run(5'd4, 4'd4, 32'h0000_0400, 2, 2, acc);
    chk("gap_dma_beats", acc, 4);

    // Reset in the middle of a burst.
    push_write(en_for(5'd20), 5'd20, 32'h0000_0500, 1'b0, 1'b0);
    push_write(en_for(5'd21), 5'd21, 32'h0000_0501, 1'b0, 1'b0);
    @(negedge clk);
    dma_req = 1'b1; dma_base = 5'd20; dma_len = 4'd4; dma_valid = 1'b0;
    acc = 0;
    do begin
      @(negedge clk);
      acc++;
    end while (!dma_rdy && acc < 20);
    chk("mid_rst_granted", dma_rdy, 1'b1);
    dma_req = 1'b0; dma_valid = 1'b1; dma_data = 32'h0000_0500;
    @(negedge clk);
    dma_data = 32'h0000_0501;
    @(negedge clk);
    dma_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 32'h0);
    chk("mid_rst_wr_data", wr_data, 32'h0);
    chk("mid_rst_dma_done", dma_done, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_dma_rdy", dma_rdy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_idle", busy, 1'b0);

`ifdef REG_WRITE_ARBITER_R0_PROTECT_EN
    // Protected register 0: handshake completes but nothing is enabled.
    push_write(32'h0, 5'd0, 32'h0000_1234, 1'b1, 1'b0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 5'd0; cpu_data = 32'h0000_1234;
    @(posedge clk);
    #1;
    chk("r0_ack", cpu_ack, 1'b1);
    chk("r0_wr_en", wr_en, 32'h0);
    chk("r0_viol", r0_viol, 1'b1);
    @(negedge clk);
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    chk("r0_viol_low", r0_viol, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_final_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
